pipeline_stall_ctrl: RTL
========================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter MC_CNT_W, default 4, width of the multicycle-EX cycle count.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the stall-cycle counter (used only with the Configuration macro).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port hazard_req, input, 1, load-use stall request from the hazard detection unit.
REQ-006 SHALL have port branch_taken, input, 1, EX-stage taken branch or jump; requires a flush.
REQ-007 SHALL have port mem_busy, input, 1, data memory not ready; the pipeline freezes.
REQ-008 SHALL have port mc_start, input, 1, EX issues a multicycle op.
REQ-009 SHALL have port mc_cycles, input, MC_CNT_W, total EX cycles of that op.
REQ-010 SHALL have outputs pc_write, if_id_write, id_ex_write and ex_mem_write, each 1 bit, stage write enables.
REQ-011 SHALL have outputs if_id_flush, id_ex_bubble and ex_mem_bubble, each 1 bit, insert a NOP into that latch.
REQ-012 SHALL have output state_o, 3 bits, current FSM state encoding.
REQ-013 SHALL have output stall_cycles, STALL_CNT_W bits, present only with the Configuration macro.

Function
REQ-014 SHALL implement a registered FSM with states RUN, STALL, FLUSH, MEM_WAIT and MULTI; all outputs are a Moore decode of the registered state, so latency is one cycle from a sampled request.
REQ-015 RUN SHALL drive all write enables 1 and all flush/bubble outputs 0.
REQ-016 STALL SHALL drive pc_write=0, if_id_write=0 and id_ex_bubble=1; all others as in RUN.
REQ-017 FLUSH SHALL drive pc_write=1, if_id_flush=1 and id_ex_bubble=1; all others as in RUN.
REQ-018 MEM_WAIT SHALL drive all four write enables 0 and all flush/bubble outputs 0.
REQ-019 MULTI SHALL drive pc_write=0, if_id_write=0, id_ex_write=0 and ex_mem_bubble=1.
REQ-020 SHALL apply this priority in every state: mem_busy, then branch_taken, then mc_start with mc_cycles>1, then hazard_req.
REQ-021 In RUN, the winner of REQ-020 SHALL select the next state: MEM_WAIT, FLUSH, MULTI or STALL; with no request, stay in RUN.
REQ-022 STALL and FLUSH SHALL last one cycle each, then re-evaluate REQ-020; a hazard_req still high in STALL yields a further STALL.
REQ-023 On MULTI entry, the countdown SHALL load mc_cycles-1; MULTI decrements it each cycle and exits to RUN on the cycle it reads 1.
REQ-024 mc_cycles of 0 or 1 SHALL be treated as no stall.
REQ-025 mc_start, hazard_req and branch_taken SHALL be ignored while in MULTI.
REQ-026 mem_busy sampled in any state SHALL enter MEM_WAIT; MEM_WAIT holds while mem_busy=1 and freezes the countdown.
REQ-027 On mem_busy=0, MEM_WAIT SHALL exit to MULTI if the countdown is nonzero, else to RUN.
REQ-028 branch_taken in STALL SHALL go to FLUSH; a pending hazard_req is then discarded.
REQ-029 Simultaneous requests SHALL resolve only by REQ-020; lower-priority requests are not queued and upstream re-asserts them.

Reset
REQ-030 rst=1 SHALL force state RUN and clear the countdown and stall_cycles to 0 asynchronously, including mid-MULTI or mid-MEM_WAIT.
REQ-031 During and after reset, outputs SHALL equal the RUN decode (write enables 1, flush/bubble 0, state_o=RUN).
REQ-032 The first state transition after reset SHALL occur on the first posedge clk after rst deasserts.

Configuration
REQ-033 Macro PIPE_STALL_CNT_EN defined SHALL instantiate stall_cycles, which increments by 1 each cycle the state is not RUN and saturates at all-ones.
REQ-034 Macro PIPE_STALL_CNT_EN undefined SHALL remove the stall_cycles port and counter, with all other behaviour identical.

Structure
REQ-035 Package pipeline_ctrl_pkg SHALL hold the state typedef, the encodings RUN=0, STALL=1, FLUSH=2, MEM_WAIT=3 and MULTI=4, and the MC_CNT_W default.
REQ-036 The countdown SHALL be a sub-module mc_countdown with load, decrement, freeze and zero-flag functions; all other logic stays in pipeline_stall_ctrl.

Verification
REQ-037 A bench SHALL check: hazard_req high 1 cycle in RUN -> next cycle state_o=1, pc_write=0, if_id_write=0, id_ex_bubble=1 -> then RUN.
REQ-038 A bench SHALL check: hazard_req and branch_taken high together -> FLUSH for 1 cycle (if_id_flush=1, id_ex_bubble=1, pc_write=1) -> no STALL follows.
REQ-039 A bench SHALL check: mc_start with mc_cycles=4 -> MULTI for exactly 3 cycles with ex_mem_bubble=1 -> RUN; mc_cycles=1 -> stays RUN.
REQ-040 A bench SHALL check: mc_cycles=5, mem_busy high for 2 cycles in the second MULTI cycle -> MEM_WAIT 2 cycles with all writes 0 -> MULTI resumes for the remaining count.
REQ-041 A bench SHALL check: rst asserted mid-MEM_WAIT, between clock edges -> immediately state_o=0 and all write enables 1; with PIPE_STALL_CNT_EN, stall_cycles=0.
REQ-042 A bench SHALL check, with PIPE_STALL_CNT_EN and STALL_CNT_W=4: 20 non-RUN cycles -> stall_cycles=15 (saturated).

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module : pipeline_ctrl_pkg
// Brief  : Shared state encoding and defaults for the pipeline stall control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    localparam int MC_CNT_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_STALL    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_MULTI    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mc_countdown.sv
// ============================================================================
// Module : mc_countdown
// Brief  : Remaining-cycle counter for multicycle EX ops (load/dec/freeze/zero).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_countdown #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         freeze,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (freeze) begin
            count_d = count_q;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// Module : pipeline_stall_ctrl
// Brief  : Moore FSM producing stage write enables / flush / bubble controls.
//          Optional stall-cycle counter enabled by macro PIPE_STALL_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MC_CNT_W    = MC_CNT_W_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard_req,
    input  logic                   branch_taken,
    input  logic                   mem_busy,
    input  logic                   mc_start,
    input  logic [MC_CNT_W-1:0]    mc_cycles,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_bubble,
`ifdef PIPE_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cycles,
`endif
    output logic [2:0]             state_o
);

    if ((MC_CNT_W < 2) || (STALL_CNT_W < 1)) begin : g_cfg_check
        $error("pipeline_stall_ctrl: invalid counter width parameters");
    end

    state_t              state_q;
    state_t              state_d;
    logic                mc_load;
    logic                mc_dec;
    logic                mc_freeze;
    logic                mc_zero;
    logic [MC_CNT_W-1:0] mc_count;
    logic                mc_go;

    assign mc_go     = mc_start && (mc_cycles > MC_CNT_W'(1));
    assign mc_dec    = (state_q == ST_MULTI);
    assign mc_freeze = (state_q == ST_MEM_WAIT);

    mc_countdown #(
        .W (MC_CNT_W)
    ) u_mc_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (mc_load),
        .load_val (mc_cycles - MC_CNT_W'(1)),
        .dec      (mc_dec),
        .freeze   (mc_freeze),
        .count    (mc_count),
        .zero     (mc_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mc_load = 1'b0;
        case (state_q)
            // Only memory stalls can interrupt a multicycle op.
            ST_MULTI: begin
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else if (mc_count <= MC_CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d = mc_zero ? ST_RUN : ST_MULTI;
                end
            end
            default: begin
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    state_d = ST_FLUSH;
                end else if (mc_go) begin
                    state_d = ST_MULTI;
                    mc_load = 1'b1;
                end else if (hazard_req) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        case (state_q)
            ST_STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ST_MEM_WAIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end
            ST_MULTI: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((state_q != ST_RUN) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire
